mcu_pixel_loader: RTL and testbench

Upstream stage of the BRAM write path in the dithering accelerator. Accepts the raw byte stream from the MCU link and packs each R, G, B byte triple into one pixel word. For every pixel it produces the frame-linear address `png_idx` and a one-cycle `MCU_TX_RDY` strobe, which the write-enable stage consumes to raise `wren_a`. It also tracks frame boundaries and provides byte-level backpressure so pixels are never dropped while memory is owned by the dither engine.

---
 rtl/dither_pkg.sv | 23 ++
 rtl/rgb2luma.sv | 27 ++
 rtl/mcu_pixel_loader.sv | 165 ++++++++++++++++
 tb/tb_mcu_pixel_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dither_pkg.sv
// Shared types and constants for the dithering accelerator BRAM write path.
// MCU_PIXEL_LOADER_GRAYSCALE_EN adds the CONV state to the loader FSM encoding.
package dither_pkg;

    localparam int unsigned PIX_W = 8;

    localparam logic [15:0] LUMA_R = 16'd77;
    localparam logic [15:0] LUMA_G = 16'd150;
    localparam logic [15:0] LUMA_B = 16'd29;

`ifdef MCU_PIXEL_LOADER_GRAYSCALE_EN
    typedef enum logic [2:0] {IDLE, GET_R, GET_G, GET_B, CONV, EMIT, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, GET_R, GET_G, GET_B, EMIT, DONE} state_t;
`endif

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } pixel_t;

endpackage

// File: rtl/rgb2luma.sv
// Luma conversion Y = (77R + 150G + 29B) >> 8; the result register loads when en_i is high.
module rgb2luma
    import dither_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  pixel_t           pix_i,
    output logic [PIX_W-1:0] y_o
);

    logic [15:0]      sum;
    logic [PIX_W-1:0] y_q;

    // Coefficients sum to 256, so the weighted sum never exceeds 16 bits.
    assign sum = LUMA_R * 16'(pix_i.r) + LUMA_G * 16'(pix_i.g) + LUMA_B * 16'(pix_i.b);

    always_ff @(posedge clk) begin
        if (rst)
            y_q <= '0;
        else if (en_i)
            y_q <= PIX_W'(sum >> 8);
    end

    assign y_o = y_q;

endmodule

// File: rtl/mcu_pixel_loader.sv
// Packs the MCU R,G,B byte stream into pixel words with frame-linear addresses and strobes.
// Define MCU_PIXEL_LOADER_GRAYSCALE_EN to insert a CONV state and emit {Y,Y,Y} luma pixels.
module mcu_pixel_loader
    import dither_pkg::*;
#(
    parameter int IMAGEY           = 64,
    parameter int IMAGEX           = 64,
    parameter int IMAGE_SIZE       = IMAGEY * IMAGEX,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
    parameter int RGB_SIZE         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic [RGB_SIZE-1:0]         rx_byte,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    input  logic                        mem_busy,
    output logic [IMAGE_ADDR_WIDTH-1:0] png_idx,
    output logic [3*RGB_SIZE-1:0]       pixel_data,
    output logic                        MCU_TX_RDY,
    output logic                        frame_done,
    output logic                        loading
);

    localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_IDX = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

    state_t                      state_q, state_d;
    logic [IMAGE_ADDR_WIDTH-1:0] cnt_q, cnt_d, idx_q, idx_d;
    logic [RGB_SIZE-1:0]         r_q, r_d, g_q, g_d;
    logic                        tx_rdy_q, tx_rdy_d, done_q, done_d, loading_q, loading_d;
    logic                        xfer, last_px;

    assign rx_ready = (state_q inside {GET_R, GET_G, GET_B}) && !mem_busy;
    assign xfer     = rx_valid && rx_ready;
    assign last_px  = (cnt_q == LAST_IDX);

`ifdef MCU_PIXEL_LOADER_GRAYSCALE_EN
    logic [RGB_SIZE-1:0] b_q, b_d;
    logic [PIX_W-1:0]    luma;
    logic                conv_en;
    pixel_t              luma_in;

    assign luma_in = '{r: r_q, g: g_q, b: b_q};

    rgb2luma u_rgb2luma (
        .clk   (clk),
        .rst   (rst),
        .en_i  (conv_en),
        .pix_i (luma_in),
        .y_o   (luma)
    );

    assign pixel_data = {luma, luma, luma};
`else
    pixel_t pix_q, pix_d;

    assign pixel_data = pix_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        r_d       = r_q;
        g_d       = g_q;
        tx_rdy_d  = 1'b0;
        done_d    = 1'b0;
        loading_d = loading_q;
`ifdef MCU_PIXEL_LOADER_GRAYSCALE_EN
        b_d       = b_q;
        conv_en   = 1'b0;
`else
        pix_d     = pix_q;
`endif
        // A restart wins over everything in flight, including a pending B transfer.
        if (frame_start) begin
            state_d   = GET_R;
            cnt_d     = '0;
            loading_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: cnt_d = '0;
                GET_R: if (xfer) begin
                    r_d     = rx_byte;
                    state_d = GET_G;
                end
                GET_G: if (xfer) begin
                    g_d     = rx_byte;
                    state_d = GET_B;
                end
                GET_B: if (xfer) begin
`ifdef MCU_PIXEL_LOADER_GRAYSCALE_EN
                    b_d     = rx_byte;
                    state_d = CONV;
`else
                    state_d  = EMIT;
                    tx_rdy_d = 1'b1;
                    idx_d    = cnt_q;
                    done_d   = last_px;
                    pix_d    = '{r: r_q, g: g_q, b: rx_byte};
`endif
                end
`ifdef MCU_PIXEL_LOADER_GRAYSCALE_EN
                CONV: begin
                    conv_en  = 1'b1;
                    state_d  = EMIT;
                    tx_rdy_d = 1'b1;
                    idx_d    = cnt_q;
                    done_d   = last_px;
                end
`endif
                EMIT: begin
                    if (last_px) begin
                        state_d   = DONE;
                        loading_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = GET_R;
                    end
                end
                DONE:    ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            r_q       <= '0;
            g_q       <= '0;
            tx_rdy_q  <= 1'b0;
            done_q    <= 1'b0;
            loading_q <= 1'b0;
`ifdef MCU_PIXEL_LOADER_GRAYSCALE_EN
            b_q       <= '0;
`else
            pix_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            r_q       <= r_d;
            g_q       <= g_d;
            tx_rdy_q  <= tx_rdy_d;
            done_q    <= done_d;
            loading_q <= loading_d;
`ifdef MCU_PIXEL_LOADER_GRAYSCALE_EN
            b_q       <= b_d;
`else
            pix_q     <= pix_d;
`endif
        end
    end

    assign png_idx    = idx_q;
    assign MCU_TX_RDY = tx_rdy_q;
    assign frame_done = done_q;
    assign loading    = loading_q;

endmodule

// File: tb/tb_mcu_pixel_loader.sv
// Directed bench for mcu_pixel_loader on a 2x2 frame; grayscale vectors run when the macro is set.
module tb_mcu_pixel_loader;

    logic        clk = 1'b0;
    logic        rst, frame_start, rx_valid, mem_busy;
    logic        rx_ready, MCU_TX_RDY, frame_done, loading;
    logic [7:0]  rx_byte;
    logic [1:0]  png_idx;
    logic [23:0] pixel_data;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    logic [23:0] exp_px [4] = '{24'h101112, 24'h131415, 24'h161718, 24'h191A1B};

    always #5 clk = ~clk;

    mcu_pixel_loader #(.IMAGEX(2), .IMAGEY(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .mem_busy    (mem_busy),
        .png_idx     (png_idx),
        .pixel_data  (pixel_data),
        .MCU_TX_RDY  (MCU_TX_RDY),
        .frame_done  (frame_done),
        .loading     (loading)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Holds the byte valid until it is taken; returns just after the transfer edge.
    task automatic send_byte(input logic [7:0] v);
        bit sent = 1'b0;
        rx_valid = 1'b1;
        rx_byte  = v;
        for (int c = 0; c < 50 && !sent; c++) begin
            #1;
            if (rx_ready) sent = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        if (!sent) chk("send_timeout", 32'(sent), 32'd1);
    endtask

    task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        send_byte(r);
        send_byte(g);
        send_byte(b);
`ifdef MCU_PIXEL_LOADER_GRAYSCALE_EN
        chk("conv_no_strobe", 32'(MCU_TX_RDY), 32'd0);
        tick();
`endif
    endtask

    task automatic chk_strobe(input logic [1:0] idx, input logic [23:0] pix, input logic done);
        chk("strobe", 32'(MCU_TX_RDY), 32'd1);
        chk("png_idx", 32'(png_idx), 32'(idx));
        chk("frame_done", 32'(frame_done), 32'(done));
`ifndef MCU_PIXEL_LOADER_GRAYSCALE_EN
        chk("pixel_data", 32'(pixel_data), 32'(pix));
`endif
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; rx_valid = 1'b0; rx_byte = '0; mem_busy = 1'b0;
        tick();
        tick();
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_strobe", 32'(MCU_TX_RDY), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_idx", 32'(png_idx), 32'd0);
        chk("rst_pix", 32'(pixel_data), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_loading", 32'(loading), 32'd0);

        // Full 2x2 frame.
        pulse_start();
        chk("start_loading", 32'(loading), 32'd1);
        chk("start_rx_ready", 32'(rx_ready), 32'd1);
        for (int p = 0; p < 4; p++) begin
            send_px(8'(8'h10 + 3 * p), 8'(8'h11 + 3 * p), 8'(8'h12 + 3 * p));
            chk_strobe(2'(p), exp_px[p], p == 3);
            chk("loading_in_emit", 32'(loading), 32'd1);
        end
        tick();
        chk("done_loading", 32'(loading), 32'd0);
        chk("done_pulse_end", 32'(frame_done), 32'd0);
        chk("done_no_strobe", 32'(MCU_TX_RDY), 32'd0);
        chk("done_idx_hold", 32'(png_idx), 32'd3);
`ifndef MCU_PIXEL_LOADER_GRAYSCALE_EN
        chk("done_pix_hold", 32'(pixel_data), 32'h191A1B);
`endif

        // Bytes offered in DONE are refused.
        rx_valid = 1'b1;
        rx_byte  = 8'h55;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("done_rx_ready", 32'(rx_ready), 32'd0);
            tick();
            chk("done_strobe", 32'(MCU_TX_RDY), 32'd0);
        end
        rx_valid = 1'b0;

        // Backpressure after the G byte.
        pulse_start();
        send_byte(8'h10);
        send_byte(8'h11);
        mem_busy = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h12;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("busy_rx_ready", 32'(rx_ready), 32'd0);
            tick();
        end
        mem_busy = 1'b0;
        send_byte(8'h12);
`ifdef MCU_PIXEL_LOADER_GRAYSCALE_EN
        tick();
`endif
        chk_strobe(2'd0, 24'h101112, 1'b0);

        // Restart after 7 bytes.
        pulse_start();
        send_px(8'h20, 8'h21, 8'h22);
        chk_strobe(2'd0, 24'h202122, 1'b0);
        send_px(8'h23, 8'h24, 8'h25);
        chk_strobe(2'd1, 24'h232425, 1'b0);
        send_byte(8'h26);
        pulse_start();
        chk("abort_no_strobe", 32'(MCU_TX_RDY), 32'd0);
        chk("abort_loading", 32'(loading), 32'd1);
        send_px(8'h30, 8'h31, 8'h32);
        chk_strobe(2'd0, 24'h303132, 1'b0);

        // Reset while waiting for G.
        send_byte(8'h40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_idx", 32'(png_idx), 32'd0);
        chk("midrst_pix", 32'(pixel_data), 32'd0);
        chk("midrst_loading", 32'(loading), 32'd0);
        chk("midrst_strobe", 32'(MCU_TX_RDY), 32'd0);
        chk("midrst_done", 32'(frame_done), 32'd0);
        rx_valid = 1'b1;
        rx_byte  = 8'h41;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
            tick();
            chk("midrst_no_strobe", 32'(MCU_TX_RDY), 32'd0);
        end
        rx_valid = 1'b0;
        pulse_start();
        send_px(8'h50, 8'h51, 8'h52);
        chk_strobe(2'd0, 24'h505152, 1'b0);

`ifdef MCU_PIXEL_LOADER_GRAYSCALE_EN
        send_px(8'hFF, 8'hFF, 8'hFF);
        chk_strobe(2'd1, 24'hFFFFFF, 1'b0);
        chk("gray_white", 32'(pixel_data), 32'hFFFFFF);
        send_px(8'h00, 8'hFF, 8'h00);
        chk_strobe(2'd2, 24'h959595, 1'b0);
        chk("gray_green", 32'(pixel_data), 32'h959595);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
